// File: rtl/uart_txq_pkg.sv
// Shared address map, QSTAT field positions and TX-queue FSM encoding.
package uart_txq_pkg;

    localparam logic [31:0] QDATA_OFS     = 32'h0;
    localparam logic [31:0] QSTAT_OFS     = 32'h4;
    localparam logic [31:0] UART_TXDT_OFS = 32'h4;
    localparam logic [31:0] UART_CTRL_OFS = 32'h8;
    localparam logic [31:0] UART_STAT_OFS = 32'hc;

    localparam int QSTAT_EMPTY_BIT = 0;
    localparam int QSTAT_FULL_BIT  = 1;
    localparam int QSTAT_CNT_LSB   = 4;
    localparam int QSTAT_CNT_MSB   = 8;
    localparam int QSTAT_OVF_BIT   = 9;
    localparam int UART_BUSY_BIT   = 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_POLL  = 2'd1,
        ST_SEND  = 2'd2,
        ST_GUARD = 2'd3
    } txq_state_e;

    function automatic logic [31:0] qstat_pack(input logic empty, input logic full,
                                               input logic [4:0] cnt, input logic ovf);
        logic [31:0] r;
        r = '0;
        r[QSTAT_EMPTY_BIT] = empty;
        r[QSTAT_FULL_BIT]  = full;
        r[QSTAT_CNT_MSB:QSTAT_CNT_LSB] = cnt;
        r[QSTAT_OVF_BIT]   = ovf;
        return r;
    endfunction

endpackage

// File: rtl/uart_txq_fifo.sv
// Byte FIFO with combinational head; push lands on the clock edge.
// Refuses a push when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    output logic                     push_rdy,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_vld && (count_q != '0);
        push_rdy = (count_q != FULL_CNT) || do_pop;
        do_push  = push_vld && push_rdy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap for free because DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);

endmodule

// File: rtl/uart_txq.sv
// Host-side TX byte queue that drains into a memory-mapped UART: INIT, then POLL/SEND/GUARD.
// Push into an idle empty queue reaches uart_we 2 cycles later; full pushes drop and set ovf.
module uart_txq
    import uart_txq_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] QBASE     = 32'hffff0040,
    parameter logic [31:0] UBASE     = 32'hffff0020,
    parameter logic [31:0] CTRL_INIT = 32'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        uart_we,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_wdata,
    input  logic [31:0] uart_rdata
);
    localparam int AW = $clog2(DEPTH);

    txq_state_e  state_q, state_d;
    logic        ovf_q, ovf_d;
    logic        qdata_hit, qstat_hit;
    logic        q_push_vld, q_push_rdy, q_pop_vld, q_empty, q_full;
    logic [7:0]  q_pop_dat;
    logic [AW:0] q_count;
    logic        fsm_we;
    logic [31:0] fsm_addr, fsm_wdata;
    logic        unused_bits;

    assign qdata_hit  = (mem_addr == QBASE + QDATA_OFS);
    assign qstat_hit  = (mem_addr == QBASE + QSTAT_OFS);
    assign q_push_vld = mem_we && qdata_hit;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (q_push_vld),
        .push_rdy (q_push_rdy),
        .push_dat (mem_wdata[7:0]),
        .pop_vld  (q_pop_vld),
        .pop_dat  (q_pop_dat),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_comb begin
        state_d   = state_q;
        fsm_we    = 1'b0;
        fsm_addr  = UBASE | UART_STAT_OFS;
        fsm_wdata = '0;
        q_pop_vld = 1'b0;
        case (state_q)
            ST_INIT: begin
                fsm_we    = 1'b1;
                fsm_addr  = UBASE | UART_CTRL_OFS;
                fsm_wdata = CTRL_INIT;
                state_d   = ST_POLL;
            end
            ST_POLL: begin
                if (!q_empty && !uart_rdata[UART_BUSY_BIT]) state_d = ST_SEND;
            end
            ST_SEND: begin
                fsm_we    = 1'b1;
                fsm_addr  = UBASE | UART_TXDT_OFS;
                fsm_wdata = {24'b0, q_pop_dat};
                q_pop_vld = 1'b1;
                state_d   = ST_GUARD;
            end
            ST_GUARD: state_d = ST_POLL;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (mem_we && qstat_hit && mem_wdata[QSTAT_OVF_BIT]) ovf_d = 1'b0;
        if (q_push_vld && !q_push_rdy)                     ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // The FSM sits in INIT while reset is held, so the bus is forced idle then.
    assign uart_we    = rst && fsm_we;
    assign uart_addr  = rst ? fsm_addr  : (UBASE | UART_STAT_OFS);
    assign uart_wdata = rst ? fsm_wdata : 32'h0;

    assign mem_rdata = qstat_hit ? qstat_pack(q_empty, q_full, 5'(q_count), ovf_q) : 32'h0;

    assign unused_bits = ^{mem_wdata[31:10], mem_wdata[8], uart_rdata[31:2], uart_rdata[0]};

endmodule
